generador_onda: RTL and testbench
=================================

Name: generador_onda

Overview:
- Programmable square-wave source; the transmit end of the wave-period measurement path.
- Drives senial_generada, which is fed back through the input synchronizer to the period meter for self-test and calibration.
- Period and high time are configurable in clock_FPGA cycles.
- Reconfiguration is glitch-free: a new setting takes effect only on a period boundary.

Parameters:
- ANCHO_CONTADOR, 32: width of the period/high-time fields and the internal cycle counter.
- PERIODO_DEFECTO, 100: active period loaded at reset, in cycles.
- ALTO_DEFECTO, 50: active high time loaded at reset, in cycles.

Ports:
- clock_FPGA  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- habilitar  input  1  level; 1 = generate, 0 = stop after the current period.
- cargar  input  1  one-cycle strobe that captures periodo_in and alto_in.
- periodo_in  input  ANCHO_CONTADOR  requested period P.
- alto_in  input  ANCHO_CONTADOR  requested high time A.
- senial_generada  output  1  registered wave output.
- fin_periodo  output  1  one-cycle pulse in the last cycle of each period.
- pendiente  output  1  a valid configuration is waiting for the next boundary.
- error_config  output  1  sticky flag; last load was rejected.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - state=REPOSO, contador=0.
  - active P/A = PERIODO_DEFECTO/ALTO_DEFECTO; shadow cleared.
  - senial_generada=0, fin_periodo=0, pendiente=0, error_config=0.
  - Reset mid-period aborts at once; no completion of the current period.
- Validity: a load is valid iff P>=2 and 1<=A<=P-1.
  - Invalid load: ignored, and error_config=1 from the next cycle.
  - A later valid load clears error_config.
- States:
  - REPOSO: output 0, contador held at 0.
    - cargar (valid) writes the active registers directly; pendiente stays 0.
    - habilitar=1 sampled -> ALTO at the next edge.
  - ALTO: senial_generada=1; contador increments each cycle.
    - When contador==A-1 -> BAJO.
  - BAJO: senial_generada=0.
    - When contador==P-1: fin_periodo=1 for this cycle; contador wraps to 0.
    - habilitar=1 -> ALTO; habilitar=0 -> REPOSO.
- Latency and timing:
  - senial_generada rises 1 cycle after habilitar is first sampled high in REPOSO.
  - Exactly A cycles high, P-A cycles low, period P.
  - Output changes only on posedge, giving a half-cycle margin to negedge samplers.
- Loads while running:
  - A valid cargar goes to the shadow register; pendiente=1.
  - The shadow is copied to active at the wrap edge (contador P-1 -> 0); pendiente clears on that edge.
  - A second cargar before the boundary overwrites the shadow (last writer wins).
- Simultaneous events:
  - cargar in the same cycle as fin_periodo: the new values bypass the shadow and govern the very next period; pendiente stays 0.
  - habilitar dropped mid-period: the current period completes fully; no truncated pulses.
- Arithmetic: contador is unsigned, ANCHO_CONTADOR bits, never exceeds P-1.

Optional Feature:
- Macro GEN_CONTADOR_PERIODOS_EN.
- Defined: adds output cantidad_periodos (16 bits).
  - Increments on every fin_periodo and wraps 0xFFFF->0.
  - Cleared by reset only.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package generador_pkg holds:
  - state encoding REPOSO/ALTO/BAJO (2-bit);
  - default constants;
  - the validity-check function.
- One sub-module, registro_config, holds:
  - shadow/active registers, validation, pendiente and error_config;
  - inputs: cargar, periodo_in, alto_in, a boundary strobe, en_reposo.
- The top level holds the FSM and contador.

Test Plan:
- Reset, then habilitar=1 with defaults -> senial_generada high 50 cycles, low 50 cycles, fin_periodo every 100 cycles; first rise 1 cycle after habilitar.
- In REPOSO, cargar P=5 A=2, then habilitar=1 -> pattern 1,1,0,0,0 repeating; pendiente never set.
- Running P=10 A=3; cargar P=4 A=1 mid-period -> pendiente=1 until the boundary, then pattern 1,0,0,0; no short or long pulse at the switch.
- cargar P=1 A=1, then P=6 A=6 -> error_config=1, waveform unchanged; then valid P=6 A=3 -> error_config=0.
- Drop habilitar during ALTO of P=8 A=4 -> the period completes (4 high, 4 low), fin_periodo pulses, output stays 0 in REPOSO.
- Assert reset_n=0 mid-ALTO -> next cycle senial_generada=0 and defaults restored. With GEN_CONTADOR_PERIODOS_EN: after 3 periods cantidad_periodos=3, then 0 after the reset.

Source files
------------

// File: rtl/generador_pkg.sv
// Shared types, default constants and load-validity check for the square-wave generator.
package generador_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ALTO   = 2'd1,
    BAJO   = 2'd2
  } estado_t;

  localparam int unsigned DEF_ANCHO   = 32;
  localparam int unsigned DEF_PERIODO = 100;
  localparam int unsigned DEF_ALTO    = 50;

  // Fields are zero-extended to this width before checking, so any counter width up to 64 works.
  localparam int unsigned ANCHO_MAX = 64;
  typedef logic [ANCHO_MAX-1:0] valor_t;

  function automatic logic config_valida(input valor_t p, input valor_t a);
    return (p >= valor_t'(2)) && (a != '0) && (a < p);
  endfunction

endpackage

// File: rtl/generador_onda_registro_config.sv
// Active/shadow period and high-time registers with validation, pendiente and error_config.
module registro_config
  import generador_pkg::*;
#(
  parameter int unsigned ANCHO_CONTADOR  = DEF_ANCHO,
  parameter int unsigned PERIODO_DEFECTO = DEF_PERIODO,
  parameter int unsigned ALTO_DEFECTO    = DEF_ALTO
) (
  input  logic                      clock_FPGA,
  input  logic                      reset_n,
  input  logic                      cargar,
  input  logic [ANCHO_CONTADOR-1:0] periodo_in,
  input  logic [ANCHO_CONTADOR-1:0] alto_in,
  input  logic                      frontera,
  input  logic                      en_reposo,
  output logic [ANCHO_CONTADOR-1:0] periodo_act,
  output logic [ANCHO_CONTADOR-1:0] alto_act,
  output logic                      pendiente,
  output logic                      error_config
);

  logic [ANCHO_CONTADOR-1:0] periodo_sombra;
  logic [ANCHO_CONTADOR-1:0] alto_sombra;
  logic                      valida;

  always_comb begin
    valida = config_valida(valor_t'(periodo_in), valor_t'(alto_in));
  end

  always_ff @(posedge clock_FPGA) begin
    if (!reset_n) begin
      periodo_act    <= ANCHO_CONTADOR'(PERIODO_DEFECTO);
      alto_act       <= ANCHO_CONTADOR'(ALTO_DEFECTO);
      periodo_sombra <= '0;
      alto_sombra    <= '0;
      pendiente      <= 1'b0;
      error_config   <= 1'b0;
    end else begin
      if (cargar) begin
        error_config <= !valida;
      end
      // A load coinciding with the boundary (or while idle) skips the shadow entirely.
      if (cargar && valida && (en_reposo || frontera)) begin
        periodo_act <= periodo_in;
        alto_act    <= alto_in;
        pendiente   <= 1'b0;
      end else if (cargar && valida) begin
        periodo_sombra <= periodo_in;
        alto_sombra    <= alto_in;
        pendiente      <= 1'b1;
      end else if (frontera && pendiente) begin
        periodo_act <= periodo_sombra;
        alto_act    <= alto_sombra;
        pendiente   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/generador_onda.sv
// Programmable glitch-free square-wave source; GEN_CONTADOR_PERIODOS_EN adds a 16-bit period counter output.
module generador_onda
  import generador_pkg::*;
#(
  parameter int unsigned ANCHO_CONTADOR  = DEF_ANCHO,
  parameter int unsigned PERIODO_DEFECTO = DEF_PERIODO,
  parameter int unsigned ALTO_DEFECTO    = DEF_ALTO
) (
  input  logic                      clock_FPGA,
  input  logic                      reset_n,
  input  logic                      habilitar,
  input  logic                      cargar,
  input  logic [ANCHO_CONTADOR-1:0] periodo_in,
  input  logic [ANCHO_CONTADOR-1:0] alto_in,
  output logic                      senial_generada,
  output logic                      fin_periodo,
  output logic                      pendiente,
  output logic                      error_config
`ifdef GEN_CONTADOR_PERIODOS_EN
  ,
  output logic [15:0]               cantidad_periodos
`endif
);

  estado_t                   estado, estado_sig;
  logic [ANCHO_CONTADOR-1:0] contador, contador_sig;
  logic [ANCHO_CONTADOR-1:0] periodo_act, alto_act;
  logic                      senial_sig;
  logic                      en_reposo;

  registro_config #(
    .ANCHO_CONTADOR (ANCHO_CONTADOR),
    .PERIODO_DEFECTO(PERIODO_DEFECTO),
    .ALTO_DEFECTO   (ALTO_DEFECTO)
  ) u_registro_config (
    .clock_FPGA  (clock_FPGA),
    .reset_n     (reset_n),
    .cargar      (cargar),
    .periodo_in  (periodo_in),
    .alto_in     (alto_in),
    .frontera    (fin_periodo),
    .en_reposo   (en_reposo),
    .periodo_act (periodo_act),
    .alto_act    (alto_act),
    .pendiente   (pendiente),
    .error_config(error_config)
  );

  always_ff @(posedge clock_FPGA) begin
    if (!reset_n) begin
      estado          <= REPOSO;
      contador        <= '0;
      senial_generada <= 1'b0;
    end else begin
      estado          <= estado_sig;
      contador        <= contador_sig;
      senial_generada <= senial_sig;
    end
  end

  always_comb begin
    estado_sig   = estado;
    contador_sig = contador;
    case (estado)
      REPOSO: begin
        contador_sig = '0;
        if (habilitar) estado_sig = ALTO;
      end
      ALTO: begin
        contador_sig = contador + ANCHO_CONTADOR'(1);
        if (contador == alto_act - ANCHO_CONTADOR'(1)) estado_sig = BAJO;
      end
      BAJO: begin
        if (contador == periodo_act - ANCHO_CONTADOR'(1)) begin
          contador_sig = '0;
          estado_sig   = habilitar ? ALTO : REPOSO;
        end else begin
          contador_sig = contador + ANCHO_CONTADOR'(1);
        end
      end
      default: begin
        contador_sig = '0;
        estado_sig   = REPOSO;
      end
    endcase
  end

  // The wave is registered from the next state so it toggles only on the clock edge.
  always_comb begin
    en_reposo   = (estado == REPOSO);
    fin_periodo = (estado == BAJO) && (contador == periodo_act - ANCHO_CONTADOR'(1));
    senial_sig  = (estado_sig == ALTO);
  end

`ifdef GEN_CONTADOR_PERIODOS_EN
  always_ff @(posedge clock_FPGA) begin
    if (!reset_n) begin
      cantidad_periodos <= '0;
    end else if (fin_periodo) begin
      cantidad_periodos <= cantidad_periodos + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_generador_onda.sv
// Directed, table-driven bench for generador_onda; honours GEN_CONTADOR_PERIODOS_EN when defined.
module tb_generador_onda;

  logic        clock_FPGA = 1'b0;
  logic        reset_n;
  logic        habilitar;
  logic        cargar;
  logic [31:0] periodo_in;
  logic [31:0] alto_in;
  logic        senial_generada;
  logic        fin_periodo;
  logic        pendiente;
  logic        error_config;
`ifdef GEN_CONTADOR_PERIODOS_EN
  logic [15:0] cantidad_periodos;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock_FPGA = ~clock_FPGA;

  generador_onda #(
    .ANCHO_CONTADOR (32),
    .PERIODO_DEFECTO(100),
    .ALTO_DEFECTO   (50)
  ) dut (
    .clock_FPGA     (clock_FPGA),
    .reset_n        (reset_n),
    .habilitar      (habilitar),
    .cargar         (cargar),
    .periodo_in     (periodo_in),
    .alto_in        (alto_in),
    .senial_generada(senial_generada),
    .fin_periodo    (fin_periodo),
    .pendiente      (pendiente),
    .error_config   (error_config)
`ifdef GEN_CONTADOR_PERIODOS_EN
    ,
    .cantidad_periodos(cantidad_periodos)
`endif
  );

  typedef struct {
    logic        hab;
    logic        car;
    logic [31:0] p;
    logic [31:0] a;
    logic        s;
    logic        f;
    logic        pe;
    logic        er;
  } vec_t;

  vec_t tabla[30];

  function automatic vec_t v(input logic hab, input logic car, input int p, input int a,
                             input logic s, input logic f, input logic pe, input logic er);
    vec_t r;
    r.hab = hab; r.car = car; r.p = p; r.a = a;
    r.s = s; r.f = f; r.pe = pe; r.er = er;
    return r;
  endfunction

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
    end
  endtask

  task automatic paso();
    @(posedge clock_FPGA);
    #1;
  endtask

  initial begin
    // Rows: inputs held through one edge, then outputs expected after that edge.
    tabla[0]  = v(0, 1, 5, 2, 0, 0, 0, 0);
    tabla[1]  = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[2]  = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[3]  = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[4]  = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[5]  = v(1, 0, 0, 0, 0, 1, 0, 0);
    tabla[6]  = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[7]  = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[8]  = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[9]  = v(1, 1, 7, 5, 0, 0, 1, 0);
    tabla[10] = v(1, 1, 3, 1, 0, 1, 1, 0);
    tabla[11] = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[12] = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[13] = v(1, 0, 0, 0, 0, 1, 0, 0);
    tabla[14] = v(1, 1, 4, 2, 1, 0, 0, 0);
    tabla[15] = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[16] = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[17] = v(1, 1, 1, 1, 0, 1, 0, 1);
    tabla[18] = v(1, 1, 6, 6, 1, 0, 0, 1);
    tabla[19] = v(1, 0, 0, 0, 1, 0, 0, 1);
    tabla[20] = v(1, 0, 0, 0, 0, 0, 0, 1);
    tabla[21] = v(1, 1, 6, 3, 0, 1, 1, 0);
    tabla[22] = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[23] = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[24] = v(1, 0, 0, 0, 1, 0, 0, 0);
    tabla[25] = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[26] = v(1, 0, 0, 0, 0, 0, 0, 0);
    tabla[27] = v(1, 0, 0, 0, 0, 1, 0, 0);
    tabla[28] = v(0, 0, 0, 0, 0, 0, 0, 0);
    tabla[29] = v(0, 0, 0, 0, 0, 0, 0, 0);

    reset_n = 1'b0; habilitar = 1'b0; cargar = 1'b0; periodo_in = '0; alto_in = '0;
    paso();
    paso();
    chk("reset senial", senial_generada, 0);
    chk("reset fin", fin_periodo, 0);
    chk("reset pendiente", pendiente, 0);
    chk("reset error", error_config, 0);
`ifdef GEN_CONTADOR_PERIODOS_EN
    chk("reset cantidad", cantidad_periodos, 0);
`endif

    // Defaults 100/50: high 50, low 50, fin in cycle 99; habilitar dropped mid-period.
    reset_n = 1'b1;
    habilitar = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      paso();
      chk($sformatf("def s%0d", i), senial_generada, (i < 50) ? 1 : 0);
      chk($sformatf("def f%0d", i), fin_periodo, (i == 99) ? 1 : 0);
      if (i == 60) habilitar = 1'b0;
    end

    for (int i = 0; i < 30; i++) begin
      habilitar  = tabla[i].hab;
      cargar     = tabla[i].car;
      periodo_in = tabla[i].p;
      alto_in    = tabla[i].a;
      paso();
      chk($sformatf("t%0d senial", i), senial_generada, tabla[i].s);
      chk($sformatf("t%0d fin", i), fin_periodo, tabla[i].f);
      chk($sformatf("t%0d pendiente", i), pendiente, tabla[i].pe);
      chk($sformatf("t%0d error", i), error_config, tabla[i].er);
    end
    cargar = 1'b0;

    // P=8 A=4, habilitar dropped during ALTO: period completes, then idle.
    cargar = 1'b1; periodo_in = 8; alto_in = 4; habilitar = 1'b0;
    paso();
    chk("p8 load pendiente", pendiente, 0);
    cargar = 1'b0; habilitar = 1'b1;
    for (int i = 0; i < 12; i++) begin
      paso();
      chk($sformatf("drop s%0d", i), senial_generada, (i < 4) ? 1 : 0);
      chk($sformatf("drop f%0d", i), fin_periodo, (i == 7) ? 1 : 0);
      if (i == 1) habilitar = 1'b0;
    end

    // Three periods with an invalid load at start, then reset mid-ALTO.
    cargar = 1'b1; periodo_in = 0; alto_in = 0; habilitar = 1'b1;
    for (int j = 0; j <= 24; j++) begin
      paso();
      cargar = 1'b0;
      chk($sformatf("run s%0d", j), senial_generada, ((j % 8) < 4) ? 1 : 0);
      chk($sformatf("run f%0d", j), fin_periodo, ((j % 8) == 7) ? 1 : 0);
    end
    chk("run error", error_config, 1);
`ifdef GEN_CONTADOR_PERIODOS_EN
    chk("cantidad 3", cantidad_periodos, 3);
`endif
    cargar = 1'b1; periodo_in = 9; alto_in = 4;
    paso();
    chk("shadow pendiente", pendiente, 1);
    chk("shadow error", error_config, 0);
    periodo_in = 3; alto_in = 3;
    paso();
    chk("pre-reset pendiente", pendiente, 1);
    chk("pre-reset error", error_config, 1);
    chk("pre-reset senial", senial_generada, 1);
    cargar = 1'b0; reset_n = 1'b0;
    paso();
    chk("mid reset senial", senial_generada, 0);
    chk("mid reset fin", fin_periodo, 0);
    chk("mid reset pendiente", pendiente, 0);
    chk("mid reset error", error_config, 0);
`ifdef GEN_CONTADOR_PERIODOS_EN
    chk("mid reset cantidad", cantidad_periodos, 0);
`endif
    reset_n = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      paso();
      chk($sformatf("post s%0d", k), senial_generada, (k < 50) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
